// File: rtl/mips_mc_pkg.sv
// mips_mc_pkg: shared definitions for the multicycle MIPS core.
//   - opcode / funct encodings of the supported instruction subset
//   - FSM state enumeration
//   - 3-bit ALU control encoding and funct-to-ALU helpers
package mips_mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXEC,
    S_ALUWB,
    S_IEXEC,
    S_IWB,
    S_BRANCH,
    S_JUMP,
    S_TRAP
  } state_t;

  // True for the R-type funct codes the core implements.
  function automatic logic funct_ok(input logic [5:0] fn);
    return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
           (fn == FN_OR)  || (fn == FN_SLT);
  endfunction

  function automatic logic [2:0] funct_to_alu(input logic [5:0] fn);
    case (fn)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mips_mc_regfile.sv
// mips_mc_regfile: 32 x 32-bit register file.
//   clk      : write clock
//   ra1/rd1  : asynchronous read port 1
//   ra2/rd2  : asynchronous read port 2
//   we/wa/wd : synchronous write port
// Register $0 always reads zero and ignores writes. Contents are not reset.
module mips_mc_regfile (
  input  logic        clk,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);

  logic [31:0] regs [0:31];

  always_ff @(posedge clk) begin
    if (we && (wa != 5'd0)) regs[wa] <= wd;
  end

  assign rd1 = (ra1 == 5'd0) ? 32'd0 : regs[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : regs[ra2];

endmodule

// File: rtl/mips_mc_core.sv
// mips_mc_core: multicycle MIPS core (control FSM + datapath) with a
// req/ready handshake to a unified variable-latency memory.
//   clk, rst            : clock, asynchronous active-high reset
//   mem_req/we/addr/wdata : memory request (held stable until mem_ready)
//   mem_rdata/mem_ready : memory response
//   pc_o                : architectural PC
//   retire              : one-cycle pulse per completed instruction
//   illegal             : sticky undefined-instruction flag
// Optional build macro MC_PERF_CNT_EN adds cycle_cnt and instret_cnt outputs.
module mips_mc_core
  import mips_mc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_PC  = 32'h0000_0180
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] pc_o,
  output logic        retire,
  output logic        illegal
`ifdef MC_PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
`endif
);

  state_t      state, state_nxt;
  logic [31:0] pc, ir, mdr, a_reg, b_reg, alu_out;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] sext, zext;

  logic [31:0] rf_rd1, rf_rd2, rf_wd;
  logic [4:0]  rf_wa;
  logic        rf_we_raw, req_raw, retire_raw;

  logic [2:0]         alu_ctl;
  logic [31:0]        alu_a, alu_b, alu_y;
  logic signed [31:0] alu_a_s, alu_b_s;
  logic               alu_zero;

  assign opcode = ir[31:26];
  assign rs     = ir[25:21];
  assign rt     = ir[20:16];
  assign rd     = ir[15:11];
  assign funct  = ir[5:0];
  assign sext   = {{16{ir[15]}}, ir[15:0]};
  assign zext   = {16'd0, ir[15:0]};

  // Reset forces the request and retire strobes low immediately, even though
  // the reset state (FETCH) would otherwise request memory.
  assign mem_req = req_raw & ~rst;
  assign retire  = retire_raw & ~rst;
  assign pc_o    = pc;

  mips_mc_regfile u_rf (
    .clk (clk),
    .ra1 (rs),
    .ra2 (rt),
    .rd1 (rf_rd1),
    .rd2 (rf_rd2),
    .we  (rf_we_raw & ~rst),
    .wa  (rf_wa),
    .wd  (rf_wd)
  );

  assign alu_a_s = alu_a;
  assign alu_b_s = alu_b;

  always_comb begin
    case (alu_ctl)
      ALU_AND: alu_y = alu_a & alu_b;
      ALU_OR:  alu_y = alu_a | alu_b;
      ALU_SUB: alu_y = alu_a - alu_b;
      ALU_SLT: alu_y = {31'd0, (alu_a_s < alu_b_s)};
      default: alu_y = alu_a + alu_b;
    endcase
  end

  assign alu_zero = (alu_y == 32'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req_raw    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = pc;
    mem_wdata  = b_reg;
    retire_raw = 1'b0;
    rf_we_raw  = 1'b0;
    rf_wa      = rt;
    rf_wd      = alu_out;
    alu_a      = a_reg;
    alu_b      = b_reg;
    alu_ctl    = ALU_ADD;
    case (state)
      S_FETCH: begin
        req_raw = 1'b1;
        if (mem_ready) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        // pc already points past this instruction: branch target = pc + off*4
        alu_a = pc;
        alu_b = {sext[29:0], 2'b00};
        case (opcode)
          OP_LW, OP_SW:     state_nxt = S_MEMADR;
          OP_RTYPE:         state_nxt = funct_ok(funct) ? S_EXEC : S_TRAP;
          OP_ADDI, OP_ANDI: state_nxt = S_IEXEC;
          OP_BEQ, OP_BNE:   state_nxt = S_BRANCH;
          OP_J:             state_nxt = S_JUMP;
          default:          state_nxt = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_b     = sext;
        state_nxt = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        req_raw  = 1'b1;
        mem_addr = alu_out;
        if (mem_ready) state_nxt = S_MEMWB;
      end
      S_MEMWB: begin
        rf_we_raw  = 1'b1;
        rf_wd      = mdr;
        retire_raw = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_MEMWR: begin
        req_raw  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = alu_out;
        if (mem_ready) begin
          retire_raw = 1'b1;
          state_nxt  = S_FETCH;
        end
      end
      S_EXEC: begin
        alu_ctl   = funct_to_alu(funct);
        state_nxt = S_ALUWB;
      end
      S_ALUWB: begin
        rf_we_raw  = 1'b1;
        rf_wa      = rd;
        retire_raw = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_IEXEC: begin
        if (opcode == OP_ANDI) begin
          alu_b   = zext;
          alu_ctl = ALU_AND;
        end else begin
          alu_b   = sext;
        end
        state_nxt = S_IWB;
      end
      S_IWB: begin
        rf_we_raw  = 1'b1;
        retire_raw = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_BRANCH: begin
        alu_ctl    = ALU_SUB;
        retire_raw = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_JUMP: begin
        retire_raw = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_TRAP:  state_nxt = S_FETCH;
      default: state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= RESET_PC;
      ir      <= 32'd0;
      mdr     <= 32'd0;
      a_reg   <= 32'd0;
      b_reg   <= 32'd0;
      alu_out <= 32'd0;
      illegal <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (mem_ready) begin
            ir <= mem_rdata;
            pc <= pc + 32'd4;
          end
        end
        S_DECODE: begin
          a_reg   <= rf_rd1;
          b_reg   <= rf_rd2;
          alu_out <= alu_y;
        end
        S_MEMADR, S_EXEC, S_IEXEC: alu_out <= alu_y;
        S_MEMRD: begin
          if (mem_ready) mdr <= mem_rdata;
        end
        S_BRANCH: begin
          // alu_out still holds the target computed during DECODE
          if (alu_zero ^ (opcode == OP_BNE)) pc <= alu_out;
        end
        S_JUMP: pc <= {pc[31:28], ir[25:0], 2'b00};
        S_TRAP: begin
          pc      <= TRAP_PC;
          illegal <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef MC_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt   <= 32'd0;
      instret_cnt <= 32'd0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (retire) instret_cnt <= instret_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mips_mc_core.sv
// tb_mips_mc_core: directed test of mips_mc_core against a unified memory
// model with a programmable number of wait states per access.
// Program space is addr[28]=1, data space addr[28]=0.
module tb_mips_mc_core;

  localparam logic [31:0] RPC  = 32'h1000_0000;
  localparam logic [31:0] TPC  = 32'h1000_0180;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req, mem_we, mem_ready, retire, illegal;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_o;
`ifdef MC_PERF_CNT_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  mips_mc_core #(.RESET_PC(RPC), .TRAP_PC(TPC)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .pc_o      (pc_o),
    .retire    (retire),
    .illegal   (illegal)
`ifdef MC_PERF_CNT_EN
    ,
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0] pmem [0:255];
  logic [31:0] dmem [0:255];
  int          lat  = 0;
  int          wcnt = 0;

  always_comb begin
    mem_ready = mem_req && (wcnt == lat);
    if (mem_addr[28]) mem_rdata = pmem[mem_addr[9:2]];
    else              mem_rdata = dmem[mem_addr[9:2]];
  end

  always @(posedge clk) begin
    if (!mem_req || mem_ready) wcnt <= 0;
    else                       wcnt <= wcnt + 1;
    if (mem_req && mem_we && mem_ready) dmem[mem_addr[9:2]] <= mem_wdata;
  end

  int total = 0;
  int bad   = 0;

  logic [31:0] rmask;
  logic        s_req [0:15];
  logic        s_we  [0:15];
  logic [31:0] s_addr[0:15];
  logic [31:0] s_wd  [0:15];
  logic [31:0] s_pc  [0:15];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Run n cycles, sampling outputs mid-cycle; return just after the next
  // rising edge so register-file writes from the last cycle are visible.
  task automatic run(input int n);
    rmask = 32'd0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rmask[i]  = retire;
      s_req[i]  = mem_req;
      s_we[i]   = mem_we;
      s_addr[i] = mem_addr;
      s_wd[i]   = mem_wdata;
      s_pc[i]   = pc_o;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      pmem[i] = 32'd0;
      dmem[i] = 32'd0;
    end
    pmem[8'h00] = 32'h2001_0005; // addi $1,$0,5
    pmem[8'h01] = 32'h2002_FFFD; // addi $2,$0,-3
    pmem[8'h02] = 32'h0022_1820; // add  $3,$1,$2
    pmem[8'h03] = 32'hAC03_0008; // sw   $3,8($0)
    pmem[8'h04] = 32'h8C04_0008; // lw   $4,8($0)
    pmem[8'h05] = 32'h1021_0002; // beq  $1,$1,+2 -> 0x20
    pmem[8'h08] = 32'h1421_0002; // bne  $1,$1,+2 (not taken)
    pmem[8'h09] = 32'h0800_0040; // j    0x40 -> 0x1000_0100
    pmem[8'h40] = 32'hFC00_0000; // opcode 3F
    pmem[8'h60] = 32'h2005_0007; // addi $5,$0,7
    pmem[8'h61] = 32'h0041_302A; // slt  $6,$2,$1
    pmem[8'h62] = 32'h0041_3822; // sub  $7,$2,$1
    pmem[8'h63] = 32'h3048_FFFF; // andi $8,$2,0xFFFF
    pmem[8'h64] = 32'h8C01_000C; // lw   $1,12($0)
    dmem[3]     = 32'hDEAD_BEEF;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req",     {31'd0, mem_req}, 32'd0);
    chk("rst_retire",  {31'd0, retire},  32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    chk("rst_pc",      pc_o,             RPC);

    rst = 1'b0;
    run(12);
    chk("p1_fetch_req",  {31'd0, s_req[0]}, 32'd1);
    chk("p1_fetch_addr", s_addr[0],         RPC);
    chk("p1_retire",     rmask,             32'h0000_0888);
    chk("p1_pc",         s_pc[11],          RPC + 32'd12);
    chk("p1_r1",         dut.u_rf.regs[1],  32'd5);
    chk("p1_r2",         dut.u_rf.regs[2],  32'hFFFF_FFFD);
    chk("p1_r3",         dut.u_rf.regs[3],  32'd2);

    lat = 3;
    run(10);
    chk("sw_retire", rmask, 32'h0000_0200);
    for (int i = 6; i < 10; i++) begin
      chk("sw_req",   {31'd0, s_req[i]}, 32'd1);
      chk("sw_we",    {31'd0, s_we[i]},  32'd1);
      chk("sw_addr",  s_addr[i],         32'd8);
      chk("sw_wdata", s_wd[i],           32'd2);
    end
    chk("sw_mem", dmem[2], 32'd2);

    run(11);
    chk("lw_retire", rmask, 32'h0000_0400);
    for (int i = 6; i < 10; i++) begin
      chk("lw_req",  {31'd0, s_req[i]}, 32'd1);
      chk("lw_we",   {31'd0, s_we[i]},  32'd0);
      chk("lw_addr", s_addr[i],         32'd8);
    end
    chk("lw_r4", dut.u_rf.regs[4], 32'd2);

    lat = 0;
    run(3);
    chk("beq_retire", rmask, 32'h0000_0004);
    chk("beq_pc",     pc_o,  RPC + 32'h20);
    run(3);
    chk("bne_retire", rmask, 32'h0000_0004);
    chk("bne_pc",     pc_o,  RPC + 32'h24);
    run(3);
    chk("j_retire", rmask, 32'h0000_0004);
    chk("j_pc",     pc_o,  32'h1000_0100);

    run(3);
    chk("trap_retire",  rmask,             32'd0);
    chk("trap_illegal", {31'd0, illegal},  32'd1);
    chk("trap_pc",      pc_o,              TPC);

    run(4);
    chk("post_trap_retire",  rmask,            32'h0000_0008);
    chk("post_trap_r5",      dut.u_rf.regs[5], 32'd7);
    chk("post_trap_illegal", {31'd0, illegal}, 32'd1);
    run(4);
    chk("slt_r6", dut.u_rf.regs[6], 32'd1);
    run(4);
    chk("sub_r7", dut.u_rf.regs[7], 32'hFFFF_FFF8);
    run(4);
    chk("andi_r8", dut.u_rf.regs[8], 32'h0000_FFFD);

    lat = 3;
    run(7);
    chk("mrd_req",  {31'd0, s_req[6]}, 32'd1);
    chk("mrd_addr", s_addr[6],         32'd12);
    #2;
    rst = 1'b1;
    #1;
    chk("mrst_req",     {31'd0, mem_req}, 32'd0);
    chk("mrst_retire",  {31'd0, retire},  32'd0);
    chk("mrst_pc",      pc_o,             RPC);
    chk("mrst_illegal", {31'd0, illegal}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("mrst_r1", dut.u_rf.regs[1], 32'd5);
`ifdef MC_PERF_CNT_EN
    chk("mrst_cycle_cnt",   cycle_cnt,   32'd0);
    chk("mrst_instret_cnt", instret_cnt, 32'd0);
`endif
    rst = 1'b0;
    run(1);
    chk("refetch_req",  {31'd0, s_req[0]}, 32'd1);
    chk("refetch_addr", s_addr[0],         RPC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_mc_core.md
Name: mips_mc_core

Overview:
- Next-generation multicycle MIPS core: the control FSM and the datapath are merged into one block.
- Adds a stall-able memory handshake (req/ready) for variable-latency unified instruction/data memory.
- Adds a parametrised reset vector, an illegal-instruction trap and an instruction-retire strobe.
- Sits between the unified memory model and the top-level testbench/SoC.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TRAP_PC, 32'h0000_0180, PC loaded when an illegal instruction is decoded.

Ports:
- clk  input  1  single system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- mem_req  output  1  memory access request
- mem_we  output  1  1 = write, 0 = read; valid while mem_req is high
- mem_addr  output  32  byte address (PC on fetch, ALUOut on load/store)
- mem_wdata  output  32  store data (B register)
- mem_rdata  input  32  read data; valid in the cycle mem_ready=1
- mem_ready  input  1  access completes in this cycle
- pc_o  output  32  current architectural PC
- retire  output  1  one-cycle pulse when an instruction completes
- illegal  output  1  sticky flag; set on an undefined opcode/funct

Behaviour:
- Reset (async, rst=1):
  - state=FETCH, pc=RESET_PC.
  - IR, MDR, A, B, ALUOut all cleared to 0.
  - mem_req=0, retire=0, illegal=0.
  - Register file is not reset; $0 always reads 0 and writes to it are ignored.
- Instruction set:
  - R-type add, sub, and, or, slt.
  - lw, sw, addi, andi (zero-extended immediate), beq, bne, j.
- FSM states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, IEXEC, IWB, BRANCH, JUMP, TRAP.
- FETCH:
  - mem_req=1, mem_we=0, mem_addr=pc.
  - Stay in FETCH while mem_ready=0.
  - On mem_ready: IR<=mem_rdata, pc<=pc+4, go to DECODE.
- DECODE:
  - A<=rf[rs], B<=rf[rt].
  - ALUOut<=pc+(signext(imm)<<2), the branch target.
  - Next state by opcode: lw/sw -> MEMADR; R -> EXEC; addi/andi -> IEXEC; beq/bne -> BRANCH; j -> JUMP; any other opcode, or an R-type funct not listed -> TRAP.
- MEMADR: ALUOut<=A+signext(imm). lw -> MEMRD; sw -> MEMWR.
- MEMRD: req with addr=ALUOut, we=0; hold until ready; MDR<=mem_rdata; go to MEMWB.
- MEMWB: rf[rt]<=MDR; retire=1; go to FETCH.
- MEMWR: req with we=1, addr=ALUOut, wdata=B; hold until ready; retire=1 in the ready cycle; go to FETCH.
- EXEC/ALUWB: EXEC computes ALUOut<=A op B. ALUWB writes rf[rd]<=ALUOut, retire=1.
- IEXEC/IWB:
  - IEXEC computes ALUOut<=A+signext(imm) for addi, or A & zeroext(imm) for andi.
  - IWB writes rf[rt]<=ALUOut, retire=1.
- BRANCH:
  - Compute A-B.
  - If (zero XOR is_bne), pc<=ALUOut.
  - retire=1; go to FETCH.
- JUMP: pc<={pc[31:28], IR[25:0], 2'b00}; retire=1.
- TRAP: pc<=TRAP_PC; illegal<=1 (sticky until reset); retire=0; go to FETCH.
- ALU and arithmetic:
  - 32-bit wraparound; no overflow exception.
  - slt is a signed compare producing 32'd1 or 32'd0.
- Memory handshake rules:
  - While in a memory state, mem_req, mem_we, mem_addr and mem_wdata stay stable until mem_ready.
  - mem_ready outside a request is ignored.
  - mem_req=0 in all non-memory states.
- Cycle counts with zero wait states: lw=5; sw, R-type, addi, andi=4; beq, bne, j=3.
- Reset asserted mid-access: mem_req drops immediately; no register-file write occurs; the next fetch is from RESET_PC.

Optional Feature:
- Macro: MC_PERF_CNT_EN.
- When defined:
  - Adds outputs cycle_cnt[31:0] and instret_cnt[31:0], both reset to 0.
  - cycle_cnt increments every cycle rst=0.
  - instret_cnt increments on each retire pulse.
  - Both wrap at 2^32.
- When undefined: these ports and registers do not exist; the rest of the behaviour is identical.

Decomposition:
- Package mips_mc_pkg holds:
  - opcode and funct constants;
  - state enum;
  - 3-bit ALU control encoding (010 add, 110 sub, 000 and, 001 or, 111 slt).
- One sub-module: mips_mc_regfile, 32x32 with 2 async read ports, 1 sync write port and $0 hardwired.
- ALU stays inline as a case on the ALU control.

Test Plan:
- Reset, then zero-wait memory, program "addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2" -> $3=2; retire pulses at cycles 4, 8, 12; pc_o=RESET_PC+12.
- sw $3,8($0) then lw $4,8($0), with mem_ready delayed 3 cycles per access -> mem_addr=8 and mem_wdata=2 held stable through the wait; $4=2; lw takes 5+3+3 cycles.
- beq $1,$1,+2 -> pc=branch_pc+4+8. bne $1,$1,+2 -> pc=branch_pc+4. Both retire in 3 cycles.
- j 0x0000040 from pc 0x1000_0000 -> pc=0x1000_0100.
- Opcode 6'h3F fetched -> illegal=1, pc=TRAP_PC, no retire pulse; the flag stays set through later instructions until rst.
- Assert rst during a MEMRD wait -> mem_req=0 in the same cycle, destination register unchanged, first fetch after reset at RESET_PC. With MC_PERF_CNT_EN, both counters read 0.
